// File: rtl/alu_chk_pkg.sv
// alu_chk_pkg
//   Shared definitions for the ALU result checker: bit positions inside the
//   5-bit ALU flag vector, the layout of the mismatch report, the checker FSM
//   state encoding and a helper that builds the mismatch vector.
//   Ports: none (package).
package alu_chk_pkg;

  // Flag vector layout: {overflow, parity, carry, sign, zero}
  localparam int FLG_Z = 0;
  localparam int FLG_S = 1;
  localparam int FLG_C = 2;
  localparam int FLG_P = 3;
  localparam int FLG_V = 4;
  localparam int FLG_W = 5;

  // Mismatch vector: {sum, ovf, par, carry, sign, zero}
  localparam int MM_W   = 6;
  localparam int MM_SUM = 5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } chk_state_t;

  // The flag bits of the mismatch vector share the flag vector's ordering, so
  // an XOR of observed and expected flags drops straight into the low bits.
  function automatic logic [MM_W-1:0] mismatch_vec(input logic sum_ne,
                                                   input logic [FLG_W-1:0] got,
                                                   input logic [FLG_W-1:0] exp);
    return {sum_ne, got ^ exp};
  endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// alu_result_checker_if
//   ALU result stream: one {a, b, sum, flags} tuple per valid/ready transfer.
//   Signals: in_valid, in_ready, in_a, in_b, in_sum (WIDTH), in_flags (5).
//   Modports: master = ALU (producer), slave = checker (consumer).
interface alu_result_checker_if
  import alu_chk_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_sum;
  logic [FLG_W-1:0] in_flags;

  modport master (output in_valid, in_a, in_b, in_sum, in_flags, input in_ready);
  modport slave  (input in_valid, in_a, in_b, in_sum, in_flags, output in_ready);
endinterface

// File: rtl/alu_flag_model.sv
// alu_flag_model
//   Combinational golden adder: produces the sum and {ovf, par, carry, sign,
//   zero} flags the ALU should have reported for operands a and b.
//   Ports: a, b (in, WIDTH); sum (out, WIDTH); flags (out, 5).
module alu_flag_model
  import alu_chk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [FLG_W-1:0] flags
);

  logic [WIDTH:0] full;

  // Overflow: operands agree in sign but the result sign differs.
  // Parity flag is 1 for an even number of ones in the sum.
  always_comb begin
    full         = {1'b0, a} + {1'b0, b};
    sum          = full[WIDTH-1:0];
    flags        = '0;
    flags[FLG_Z] = (full[WIDTH-1:0] == '0);
    flags[FLG_S] = full[WIDTH-1];
    flags[FLG_C] = full[WIDTH];
    flags[FLG_P] = ~^full[WIDTH-1:0];
    flags[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) & (full[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_result_checker.sv
// alu_result_checker
//   Streaming checker for the adder ALU. Stage 1 registers each accepted
//   tuple with its recomputed sum/flags; stage 2 compares and emits a
//   one-cycle chk_valid strobe with pass/mismatch, updating saturating
//   pass/fail counters and a sticky error bit. With halt_on_fail set, the
//   first mismatch stops further acceptance until clear.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     in_if (slave)     ALU result stream
//     halt_on_fail      stop accepting after a mismatch
//     clear             pulse: zero counters/err_sticky, leave HALT
//     chk_valid/chk_pass/chk_mismatch   per-tuple result
//     pass_cnt/fail_cnt (CNT_W), err_sticky
//   Build option ALU_CHK_FIRST_FAIL_EN adds ff_valid, ff_a, ff_b, ff_sum,
//   ff_flags, ff_exp_sum, ff_exp_flags capturing the first failing tuple.
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_result_checker_if.slave in_if,
  input  logic             halt_on_fail,
  input  logic             clear,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [MM_W-1:0]  chk_mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky
`ifdef ALU_CHK_FIRST_FAIL_EN
  ,
  output logic             ff_valid,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_sum,
  output logic [FLG_W-1:0] ff_flags,
  output logic [WIDTH-1:0] ff_exp_sum,
  output logic [FLG_W-1:0] ff_exp_flags
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  chk_state_t state_q, state_d;

  logic             accept;
  logic [WIDTH-1:0] model_sum;
  logic [FLG_W-1:0] model_flags;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_sum;
  logic [FLG_W-1:0] s1_flags;
  logic [WIDTH-1:0] s1_exp_sum;
  logic [FLG_W-1:0] s1_exp_flags;
`ifdef ALU_CHK_FIRST_FAIL_EN
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
`endif

  logic [MM_W-1:0]  s2_mm;
  logic             s2_fail;

  // in_ready is forced low while rst is asserted, so no tuple is taken on
  // the reset cycle regardless of the state register's prior contents.
  assign in_if.in_ready = (state_q == ST_RUN) & ~rst;
  assign accept         = in_if.in_valid & in_if.in_ready;

  alu_flag_model #(.WIDTH(WIDTH)) u_model (
    .a     (in_if.in_a),
    .b     (in_if.in_b),
    .sum   (model_sum),
    .flags (model_flags)
  );

  assign s2_mm   = mismatch_vec(s1_sum != s1_exp_sum, s1_flags, s1_exp_flags);
  assign s2_fail = s1_valid & (|s2_mm);

  // Clear wins over a mismatch arriving on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (!clear && s2_fail && halt_on_fail) state_d = ST_HALT;
      ST_HALT: if (clear) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= accept;
  end

  // Payload registers load only on a transfer, so undriven inputs while
  // in_valid is low never reach the compare stage.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sum       <= in_if.in_sum;
      s1_flags     <= in_if.in_flags;
      s1_exp_sum   <= model_sum;
      s1_exp_flags <= model_flags;
`ifdef ALU_CHK_FIRST_FAIL_EN
      s1_a         <= in_if.in_a;
      s1_b         <= in_if.in_b;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid    <= 1'b0;
      chk_pass     <= 1'b0;
      chk_mismatch <= '0;
    end else begin
      chk_valid    <= s1_valid;
      chk_pass     <= s1_valid & ~(|s2_mm);
      chk_mismatch <= s1_valid ? s2_mm : '0;
    end
  end

  // A result landing on a clear cycle is reported but neither counted nor
  // allowed to set err_sticky.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else if (s1_valid) begin
      if (s2_fail) begin
        err_sticky <= 1'b1;
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
      end else begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_ONE;
      end
    end
  end

`ifdef ALU_CHK_FIRST_FAIL_EN
  // Only the first failure after rst/clear is captured; later ones are
  // ignored while ff_valid is set.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ff_valid <= 1'b0;
    end else if (s2_fail && !ff_valid) begin
      ff_valid     <= 1'b1;
      ff_a         <= s1_a;
      ff_b         <= s1_b;
      ff_sum       <= s1_sum;
      ff_flags     <= s1_flags;
      ff_exp_sum   <= s1_exp_sum;
      ff_exp_flags <= s1_exp_flags;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker
//   Self-checking bench for alu_result_checker (CNT_W=4 so saturation is
//   reachable). A behavioural model written with integer arithmetic and a
//   queue of in-flight tuples predicts every output each cycle; directed
//   steps additionally pin down the documented example values.
//   Optional build macro ALU_CHK_FIRST_FAIL_EN enables first-fail checks.
module tb_alu_result_checker;

  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          halt_on_fail;
  logic          clear;
  logic          chk_valid;
  logic          chk_pass;
  logic [5:0]    chk_mismatch;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic          err_sticky;
`ifdef ALU_CHK_FIRST_FAIL_EN
  logic          ff_valid;
  logic [15:0]   ff_a, ff_b, ff_sum, ff_exp_sum;
  logic [4:0]    ff_flags, ff_exp_flags;
`endif

  alu_result_checker_if #(.WIDTH(16)) bus ();

  alu_result_checker #(.WIDTH(16), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus),
    .halt_on_fail (halt_on_fail),
    .clear        (clear),
    .chk_valid    (chk_valid),
    .chk_pass     (chk_pass),
    .chk_mismatch (chk_mismatch),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt),
    .err_sticky   (err_sticky)
`ifdef ALU_CHK_FIRST_FAIL_EN
    ,
    .ff_valid     (ff_valid),
    .ff_a         (ff_a),
    .ff_b         (ff_b),
    .ff_sum       (ff_sum),
    .ff_flags     (ff_flags),
    .ff_exp_sum   (ff_exp_sum),
    .ff_exp_flags (ff_exp_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic [4:0]  flags;
    int          due;
  } tup_t;

  tup_t pend[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_no = 0;

  bit         m_halt = 1'b0;
  int         m_pass = 0;
  int         m_fail = 0;
  bit         m_sticky = 1'b0;
  bit         e_valid = 1'b0;
  bit         e_pass = 1'b0;
  logic [5:0] e_mm = '0;
  bit         m_after_rst = 1'b0;
  bit         m_ff_valid = 1'b0;
  tup_t       m_ff;
  logic [15:0] m_ff_es;
  logic [4:0]  m_ff_ef;

  // Returns {flags, sum} from plain integer arithmetic.
  function automatic logic [20:0] ref_alu(input logic [15:0] a, input logic [15:0] b);
    int unsigned u;
    int          sv;
    logic [15:0] s;
    logic [4:0]  f;
    u    = int'(a) + int'(b);
    s    = u[15:0];
    sv   = int'($signed(a)) + int'($signed(b));
    f[4] = (sv > 32767) || (sv < -32768);
    f[3] = ($countones(s) % 2) == 0;
    f[2] = (u > 65535);
    f[1] = (s > 16'h7FFF);
    f[0] = (s == 16'h0000);
    return {f, s};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready, advance the model across the edge, then
  // check all registered outputs 1 time unit after the edge.
  task automatic tick();
    bit          acc;
    tup_t        t;
    tup_t        r_t;
    logic [20:0] r;
    #1;
    checkOutput("in_ready", bus.in_ready, (!m_halt && !rst));
    acc = (bus.in_valid === 1'b1) && !m_halt && !rst;
    if (acc) begin
      t.a = bus.in_a; t.b = bus.in_b; t.sum = bus.in_sum; t.flags = bus.in_flags;
    end
    @(posedge clk);
    #1;
    edge_no++;
    if (rst) begin
      pend.delete();
      m_halt = 0; m_pass = 0; m_fail = 0; m_sticky = 0;
      e_valid = 0; e_pass = 0; e_mm = '0; m_ff_valid = 0; m_after_rst = 1;
    end else begin
      m_after_rst = 0; e_valid = 0; e_pass = 0; e_mm = '0;
      if (pend.size() > 0 && pend[0].due == edge_no) begin
        r_t = pend.pop_front();
        r   = ref_alu(r_t.a, r_t.b);
        e_mm[5] = (r_t.sum !== r[15:0]);
        for (int i = 0; i < 5; i++) e_mm[i] = (r_t.flags[i] !== r[16+i]);
        e_valid = 1;
        e_pass  = (e_mm == 6'd0);
        if (!clear) begin
          if (e_pass) begin
            if (m_pass < CNT_MAX) m_pass++;
          end else begin
            if (m_fail < CNT_MAX) m_fail++;
            m_sticky = 1;
            if (halt_on_fail) m_halt = 1;
            if (!m_ff_valid) begin
              m_ff_valid = 1; m_ff = r_t; m_ff_es = r[15:0]; m_ff_ef = r[20:16];
            end
          end
        end
      end
      if (clear) begin
        m_pass = 0; m_fail = 0; m_sticky = 0; m_halt = 0; m_ff_valid = 0;
      end
      if (acc) begin
        t.due = edge_no + 1;
        pend.push_back(t);
      end
    end
    checkOutput("chk_valid", chk_valid, e_valid);
    if (e_valid || m_after_rst) begin
      checkOutput("chk_pass", chk_pass, e_pass);
      checkOutput("chk_mismatch", chk_mismatch, e_mm);
    end
    checkOutput("pass_cnt", pass_cnt, m_pass);
    checkOutput("fail_cnt", fail_cnt, m_fail);
    checkOutput("err_sticky", err_sticky, m_sticky);
`ifdef ALU_CHK_FIRST_FAIL_EN
    checkOutput("ff_valid", ff_valid, m_ff_valid);
    if (m_ff_valid) begin
      checkOutput("ff_a", ff_a, m_ff.a);
      checkOutput("ff_b", ff_b, m_ff.b);
      checkOutput("ff_sum", ff_sum, m_ff.sum);
      checkOutput("ff_flags", ff_flags, m_ff.flags);
      checkOutput("ff_exp_sum", ff_exp_sum, m_ff_es);
      checkOutput("ff_exp_flags", ff_exp_flags, m_ff_ef);
    end
`endif
  endtask

  task automatic applyStimulus(input bit v, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] s, input logic [4:0] f, input bit clr);
    bus.in_valid = v;
    if (v) begin
      bus.in_a = a; bus.in_b = b; bus.in_sum = s; bus.in_flags = f;
    end else begin
      bus.in_a = 'x; bus.in_b = 'x; bus.in_sum = 'x; bus.in_flags = 'x;
    end
    clear = clr;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 5'h0, 1'b0);
  endtask

  task automatic applyGood(input logic [15:0] a, input logic [15:0] b);
    logic [20:0] r;
    r = ref_alu(a, b);
    applyStimulus(1'b1, a, b, r[15:0], r[20:16], 1'b0);
  endtask

  initial begin
    logic [15:0] ra, rb, rs;
    logic [4:0]  rf;
    logic [20:0] rr;
    int          k;
    bit          rv;
    bit          rc;

    rst = 1'b1; halt_on_fail = 1'b0; clear = 1'b0; bus.in_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    checkOutput("rst_chk_valid", chk_valid, 0);
    checkOutput("rst_chk_pass", chk_pass, 0);
    checkOutput("rst_chk_mismatch", chk_mismatch, 0);
    checkOutput("rst_pass_cnt", pass_cnt, 0);
    checkOutput("rst_fail_cnt", fail_cnt, 0);
    checkOutput("rst_err_sticky", err_sticky, 0);
    idle(1);

    // Example 1: carry out to zero result
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 5'b01101, 1'b0);
    idle(1);
    checkOutput("ex1_valid", chk_valid, 1);
    checkOutput("ex1_pass", chk_pass, 1);
    checkOutput("ex1_pass_cnt", pass_cnt, 1);

    // Example 2: correct then wrong parity flag
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b00110, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b01110, 1'b0);
    checkOutput("ex2a_pass", chk_pass, 1);
    checkOutput("ex2a_pass_cnt", pass_cnt, 2);
    idle(1);
    checkOutput("ex2b_mismatch", chk_mismatch, 6'b001000);
    checkOutput("ex2b_fail_cnt", fail_cnt, 1);
    checkOutput("ex2b_sticky", err_sticky, 1);

    // Example 3: signed overflow, then wrong sum
    applyStimulus(1'b1, 16'hFFFF, 16'h8000, 16'h7FFF, 5'b10100, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 16'h8000, 16'h7FFE, 5'b10100, 1'b0);
    checkOutput("ex3a_pass", chk_pass, 1);
    checkOutput("ex3a_pass_cnt", pass_cnt, 3);
    idle(1);
    checkOutput("ex3b_mismatch", chk_mismatch, 6'b100000);
    checkOutput("ex3b_pass", chk_pass, 0);
    checkOutput("ex3b_fail_cnt", fail_cnt, 2);

    // Failing result coincides with clear: reported, not counted
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 16'h0001, 5'b01101, 1'b0);
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 5'h0, 1'b1);
    checkOutput("clr_valid", chk_valid, 1);
    checkOutput("clr_pass", chk_pass, 0);
    checkOutput("clr_pass_cnt", pass_cnt, 0);
    checkOutput("clr_fail_cnt", fail_cnt, 0);
    checkOutput("clr_sticky", err_sticky, 0);

    // Example 4: halt on fail with a back-to-back stream
    halt_on_fail = 1'b1;
    applyGood(16'h0001, 16'h0002);
    applyStimulus(1'b1, 16'h0001, 16'h0002, 16'h0004, 5'b01000, 1'b0);
    applyGood(16'h0010, 16'h0020);
    applyGood(16'h0100, 16'h0100);
    checkOutput("halt_t3_valid", chk_valid, 1);
    checkOutput("halt_t3_pass", chk_pass, 1);
    checkOutput("halt_pass_cnt", pass_cnt, 2);
    checkOutput("halt_fail_cnt", fail_cnt, 1);
    checkOutput("halt_in_ready", bus.in_ready, 0);
    idle(2);
    checkOutput("halt_t4_dropped", chk_valid, 0);
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 5'h0, 1'b1);
    checkOutput("resume_in_ready", bus.in_ready, 1);
    checkOutput("resume_pass_cnt", pass_cnt, 0);
    checkOutput("resume_fail_cnt", fail_cnt, 0);
    halt_on_fail = 1'b0;

    // Example 5: pass counter saturation
    for (int i = 0; i < 17; i++) applyGood(16'($urandom), 16'($urandom));
    idle(1);
    checkOutput("sat_pass_cnt", pass_cnt, 4'hF);
    checkOutput("sat_fail_cnt", fail_cnt, 0);

    // Random traffic with corruption, sporadic clear and halt
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom % 4) != 0;
      ra = 16'($urandom); rb = 16'($urandom);
      rr = ref_alu(ra, rb);
      rs = rr[15:0]; rf = rr[20:16];
      if (($urandom % 3) == 0) begin
        k = $urandom % 21;
        if (k < 16) rs[k] = ~rs[k];
        else        rf[k-16] = ~rf[k-16];
      end
      rc = ($urandom % 20) == 0;
      halt_on_fail = ($urandom % 8) == 0;
      applyStimulus(rv, ra, rb, rs, rf, rc);
    end
    halt_on_fail = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 5'h0, 1'b1);

    // Mid-stream reset drops the in-flight tuple
    applyGood(16'h1234, 16'h4321);
    applyGood(16'h8000, 16'h8000);
    rst = 1'b1;
    idle(1);
    checkOutput("midrst_valid", chk_valid, 0);
    rst = 1'b0;
    idle(2);
    checkOutput("midrst_no_result", chk_valid, 0);

`ifdef ALU_CHK_FIRST_FAIL_EN
    // Example 6: first failure is held, clear releases it
    applyStimulus(1'b1, 16'h0005, 16'h0006, 16'h0000, 5'b00000, 1'b0);
    applyStimulus(1'b1, 16'h0007, 16'h0008, 16'h0000, 5'b00000, 1'b0);
    idle(2);
    checkOutput("ff_hold_valid", ff_valid, 1);
    checkOutput("ff_hold_a", ff_a, 16'h0005);
    checkOutput("ff_hold_exp_sum", ff_exp_sum, 16'h000B);
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 5'h0, 1'b1);
    checkOutput("ff_cleared", ff_valid, 0);
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
